// File: rtl/kcpsm6_io_hub.sv
// kcpsm6 port-bus hub: output registers, registered input mux and an edge-triggered interrupt controller.
// Define KCPSM6_IO_HUB_IRQ_SYNC_EN to pass irq_src through a two-flop synchronizer before edge detection.
module kcpsm6_io_hub #(
    parameter int         NUM_OUT   = 4,
    parameter int         NUM_IN    = 4,
    parameter int         NUM_IRQ   = 4,
    parameter logic [7:0] OUT_BASE  = 8'h00,
    parameter logic [7:0] IN_BASE   = 8'h00,
    parameter logic [7:0] CTRL_BASE = 8'hF0,
    parameter logic [7:0] OUT_RESET = 8'h00
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             port_id,
    input  logic                   write_strobe,
    input  logic                   k_write_strobe,
    input  logic                   read_strobe,
    input  logic [7:0]             out_port,
    output logic [7:0]             in_port,
    output logic                   interrupt,
    input  logic                   interrupt_ack,
    output logic [NUM_OUT*8-1:0]   gpio_out,
    output logic [NUM_OUT-1:0]     out_strobe,
    input  logic [NUM_IN*8-1:0]    gpio_in,
    output logic [NUM_IN-1:0]      in_strobe,
    input  logic [NUM_IRQ-1:0]     irq_src
);

    localparam logic [7:0] PEND_ADDR = CTRL_BASE;
    localparam logic [7:0] MASK_ADDR = CTRL_BASE + 8'd1;

    logic [7:0]         out_idx;
    logic [7:0]         in_idx;
    logic [3:0]         k_idx;
    logic               pend_wr;
    logic               mask_wr;
    logic [NUM_OUT-1:0] out_wr;
    logic [NUM_IN-1:0]  in_rd;
    logic [7:0]         rd_data;
    logic [NUM_IRQ-1:0] pend;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] hist;
    logic [NUM_IRQ-1:0] irq_s;
    logic [NUM_IRQ-1:0] irq_evt;
    logic [NUM_IRQ-1:0] w1c;
    logic               in_service;

    assign out_idx = port_id - OUT_BASE;
    assign in_idx  = port_id - IN_BASE;
    assign k_idx   = port_id[3:0] - OUT_BASE[3:0];
    assign pend_wr = write_strobe && (port_id == PEND_ADDR);
    assign mask_wr = write_strobe && (port_id == MASK_ADDR);

    // Controller addresses shadow any output register mapped on top of them.
    always_comb begin
        out_wr = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            out_wr[i] = (write_strobe && !pend_wr && !mask_wr && (out_idx == 8'(i))) ||
                        (k_write_strobe && (k_idx == 4'(i)));
        end
    end

    always_comb begin
        rd_data = '0;
        in_rd   = '0;
        if (port_id == PEND_ADDR) begin
            rd_data = 8'(pend);
        end else if (port_id == MASK_ADDR) begin
            rd_data = 8'(mask);
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (in_idx == 8'(i)) begin
                    rd_data  = gpio_in[i*8 +: 8];
                    in_rd[i] = read_strobe;
                end
            end
        end
    end

`ifdef KCPSM6_IO_HUB_IRQ_SYNC_EN
    localparam logic [NUM_IRQ-1:0] HIST_RESET = '0;
    logic [NUM_IRQ-1:0] sync_1;
    logic [NUM_IRQ-1:0] sync_2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= irq_src;
            sync_2 <= sync_1;
        end
    end

    assign irq_s = sync_2;
`else
    // All-ones history: a source already high when reset releases is not an edge.
    localparam logic [NUM_IRQ-1:0] HIST_RESET = '1;
    assign irq_s = irq_src;
`endif

    assign irq_evt = irq_s & ~hist;
    assign w1c     = pend_wr ? out_port[NUM_IRQ-1:0] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpio_out   <= {NUM_OUT{OUT_RESET}};
            out_strobe <= '0;
            in_strobe  <= '0;
            in_port    <= '0;
            interrupt  <= 1'b0;
            pend       <= '0;
            mask       <= '0;
            hist       <= HIST_RESET;
            in_service <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (out_wr[i]) gpio_out[i*8 +: 8] <= out_port;
            end
            out_strobe <= out_wr;
            in_strobe  <= in_rd;
            in_port    <= rd_data;
            hist       <= irq_s;
            // A fresh edge outranks a simultaneous write-1-to-clear.
            pend       <= (pend & ~w1c) | irq_evt;
            if (mask_wr) mask <= out_port[NUM_IRQ-1:0];
            if (interrupt_ack)  in_service <= 1'b1;
            else if (pend_wr)   in_service <= 1'b0;
            interrupt  <= (|(pend & mask)) && !in_service && !interrupt_ack;
        end
    end

endmodule

// File: doc/kcpsm6_io_hub.md
Name: kcpsm6_io_hub

Overview:
- Parametrised I/O and interrupt hub between the kcpsm6 processor port bus and fabric logic.
- Decodes port_id into NUM_OUT output registers and NUM_IN input ports, and drives the processor's in_port through a registered read mux.
- Contains an NUM_IRQ-source interrupt controller: edge capture, mask, pending, and an in-service flag.
- Owns the processor's interrupt input, which the processor wrapper currently ties low.

Parameters:
- NUM_OUT, 4: number of 8-bit output registers (1..16).
- NUM_IN, 4: number of 8-bit input ports (1..16).
- NUM_IRQ, 4: number of interrupt sources (1..8).
- OUT_BASE, 8'h00: first output port_id.
- IN_BASE, 8'h00: first input port_id.
- CTRL_BASE, 8'hF0: controller registers; CTRL_BASE+0 = PEND, CTRL_BASE+1 = MASK.
- OUT_RESET, 8'h00: reset value of every output register.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- port_id  in  8  processor port address.
- write_strobe  in  1  processor OUTPUT strobe.
- k_write_strobe  in  1  processor OUTPUTK strobe.
- read_strobe  in  1  processor INPUT strobe.
- out_port  in  8  processor write data.
- in_port  out  8  processor read data, registered.
- interrupt  out  1  processor interrupt request, registered.
- interrupt_ack  in  1  processor interrupt acknowledge.
- gpio_out  out  NUM_OUT*8  output registers; byte i = register i.
- out_strobe  out  NUM_OUT  one-cycle pulse when register i is written.
- gpio_in  in  NUM_IN*8  input ports; byte i = port i.
- in_strobe  out  NUM_IN  one-cycle pulse when port i is read.
- irq_src  in  NUM_IRQ  interrupt sources, rising-edge sensitive.

Behaviour:
- Reset values:
  - gpio_out bytes = OUT_RESET.
  - out_strobe, in_strobe, in_port, interrupt, PEND, MASK, in_service = 0.
  - Edge-detect history register = all ones, so a source already high at reset release causes no event.
- Write decode (write_strobe):
  - port_id == CTRL_BASE+0: PEND &= ~out_port[NUM_IRQ-1:0] (write-1-to-clear); also clears in_service.
  - port_id == CTRL_BASE+1: MASK <= out_port[NUM_IRQ-1:0].
  - Else, port_id - OUT_BASE in 0..NUM_OUT-1: register i <= out_port.
  - CTRL decode has priority over OUT decode when ranges overlap.
- Write decode (k_write_strobe):
  - Index = port_id[3:0] - OUT_BASE[3:0], modulo 16.
  - If index < NUM_OUT, that register is written. Never touches CTRL.
- Write timing: the register updates on the clock edge where the strobe is high. out_strobe[i] is high for exactly the following cycle.
- Unmapped writes: ignored, no strobe.
- Read path:
  - in_port <= mux(port_id) every cycle, so valid one cycle after port_id; kcpsm6 holds port_id for two cycles.
  - Mux sources: CTRL_BASE+0 -> PEND; CTRL_BASE+1 -> MASK (zero-extended); IN_BASE+i -> gpio_in byte i; unmapped -> 8'h00.
  - CTRL has priority over IN on overlap.
  - read_strobe on IN_BASE+i pulses in_strobe[i] one cycle later, for one cycle.
  - CTRL reads have no side effect.
- Interrupt controller:
  - Event i = irq_src[i] & ~hist[i]; hist <= irq_src every cycle.
  - Event sets PEND[i] regardless of MASK.
  - Event and W1C on the same bit in the same cycle: set wins.
  - in_service is set on the interrupt_ack cycle and cleared by any PEND write.
  - interrupt <= |(PEND & MASK) & ~in_service & ~interrupt_ack, so interrupt drops the cycle after ack.
  - After ack, interrupt stays low until firmware writes PEND. If enabled pending bits remain after that write, interrupt re-asserts on the next cycle.
- Reset mid-operation: all state returns to reset values immediately, including strobes and interrupt.

Optional Feature:
- Macro: KCPSM6_IO_HUB_IRQ_SYNC_EN.
- Defined: irq_src passes through a two-flop synchronizer (reset 0) before edge detection; hist also resets to 0 in this mode. PEND sets 3 cycles after the source rises, and interrupt asserts 4 cycles after.
- Undefined: irq_src is assumed synchronous to clk. PEND sets on the first edge where the rise is sampled, and interrupt asserts one cycle later.

Test Plan:
- Reset state: assert reset, defaults → gpio_out = 32'h00000000, interrupt = 0, in_port = 0. Release reset with irq_src = 4'hF → PEND remains 0.
- Output writes:
  - OUTPUT 8'hA5 to port_id 8'h02 → gpio_out[23:16] = A5 and out_strobe = 4'b0100 for one cycle.
  - OUTPUTK 8'h3C to port_id 8'h41 → byte1 = 3C.
  - OUTPUT to 8'h07 → no change, no strobe.
- Input read: gpio_in byte3 = 8'h5A, port_id = 8'h03 → in_port = 5A the next cycle. read_strobe → in_strobe = 4'b1000 for one cycle. port_id = 8'h20 → in_port = 00.
- Interrupt handshake:
  - MASK = 4'h2, pulse irq_src[1] → PEND = 2, interrupt = 1.
  - interrupt_ack → interrupt = 0 the next cycle and stays 0.
  - W1C 8'h02 to 8'hF0 → PEND = 0, interrupt stays 0.
- Masking and re-assert:
  - MASK = 0, pulse irq_src[0] → PEND = 1, interrupt = 0. Then MASK = 1 → interrupt = 1.
  - ack, then W1C 8'h00 with PEND still 1 → interrupt re-asserts one cycle later.
- Collision: irq_src[2] rise in the same cycle as W1C 8'h04 → PEND[2] = 1. Assert reset during pending interrupt → PEND = 0, interrupt = 0 immediately.
